// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: stall chain, ID interlocks,
// long-op register scoreboard and fetch redirect. Optional macro: HAZARD_DELAY_SLOT_EN.
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 2,
  parameter int MAX_LONG       = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_run,
  input  logic                              i_fetch_done,
  input  logic [NUM_SRC-1:0]                i_dec_src_valid,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] i_dec_src_addr,
  input  logic                              i_dec_reg_wb,
  input  logic [REG_ADDR_WIDTH-1:0]         i_dec_dst,
  input  logic                              i_dec_long,
  input  logic                              i_exec_reg_wb,
  input  logic [REG_ADDR_WIDTH-1:0]         i_exec_dst,
  input  logic                              i_exec_mem_read,
  input  logic                              i_exec_branch,
  input  logic [ADDR_WIDTH-1:0]             i_exec_branch_target,
  input  logic                              i_long_done,
  input  logic [REG_ADDR_WIDTH-1:0]         i_long_dst,
  input  logic                              i_mem_done,
  output logic                              o_fetch_stall,
  output logic                              o_decode_stall,
  output logic                              o_exec_stall,
  output logic                              o_mem_stall,
  output logic                              o_wb_stall,
  output logic                              o_fetch_flush,
  output logic                              o_decode_flush,
  output logic                              o_exec_flush,
  output logic                              o_mem_flush,
  output logic                              o_wb_flush,
  output logic                              o_fetch_redirect,
  output logic [ADDR_WIDTH-1:0]             o_fetch_redirect_target,
  output logic                              o_sb_full
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int CNT_W    = $clog2(MAX_LONG + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [NUM_REGS-1:0]       r_busy;
  cnt_t                      r_long_cnt;
  logic                      r_redir_pend;
  logic [ADDR_WIDTH-1:0]     r_redir_addr;

  logic                      w_active;
  logic                      w_exec_load;
  logic [REG_ADDR_WIDTH-1:0] w_src;
  logic                      w_load_use;
  logic                      w_raw;
  logic                      w_waw;
  logic                      w_full;
  logic                      w_cap;
  logic                      w_hz;
  logic                      w_mem_stall;
  logic                      w_exec_stall;
  logic                      w_decode_stall;
  logic                      w_fetch_stall;
  logic                      w_redirect;
  logic [ADDR_WIDTH-1:0]     w_target;
  logic                      w_branch_bubble;
  logic                      w_issue;
  logic                      w_retire;
  logic [NUM_REGS-1:0]       w_busy_nxt;
  cnt_t                      w_cnt_nxt;

  assign w_active    = i_run & ~i_rst;
  assign w_exec_load = i_exec_mem_read & i_exec_reg_wb;

  // Source operand checks against the load in EX and the scoreboard
  always_comb begin
    w_src      = '0;
    w_load_use = 1'b0;
    w_raw      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src = i_dec_src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (i_dec_src_valid[i]) begin
        if (w_exec_load && (w_src == i_exec_dst) && (w_src != '0)) w_load_use = 1'b1;
        if (r_busy[w_src]) w_raw = 1'b1;
      end
    end
  end

  assign w_waw  = i_dec_reg_wb & r_busy[i_dec_dst];
  assign w_full = (r_long_cnt == cnt_t'(MAX_LONG));
  assign w_cap  = i_dec_long & w_full;
  assign w_hz   = w_load_use | w_raw | w_waw | w_cap;

  assign w_mem_stall    = ~i_mem_done;
  assign w_exec_stall   = w_mem_stall;
  assign w_decode_stall = w_exec_stall | w_hz;
  assign w_fetch_stall  = w_decode_stall | ~i_fetch_done;

  assign w_redirect = i_exec_branch | r_redir_pend;
  assign w_target   = i_exec_branch ? i_exec_branch_target : r_redir_addr;

`ifdef HAZARD_DELAY_SLOT_EN
  // The instruction in ID is the branch delay slot and must survive
  assign w_branch_bubble = 1'b0;
`else
  assign w_branch_bubble = i_exec_branch;
`endif

  always_comb begin
    o_fetch_stall           = 1'b1;
    o_decode_stall          = 1'b1;
    o_exec_stall            = 1'b1;
    o_mem_stall             = 1'b1;
    o_wb_stall              = 1'b1;
    o_fetch_flush           = 1'b1;
    o_decode_flush          = 1'b1;
    o_exec_flush            = 1'b1;
    o_mem_flush             = 1'b1;
    o_wb_flush              = 1'b1;
    o_fetch_redirect        = 1'b0;
    o_fetch_redirect_target = w_target;
    o_sb_full               = w_full;
    if (w_active) begin
      o_wb_stall       = 1'b0;
      o_mem_stall      = w_mem_stall;
      o_exec_stall     = w_exec_stall;
      o_decode_stall   = w_decode_stall;
      o_fetch_stall    = w_fetch_stall;
      o_wb_flush       = 1'b0;
      o_mem_flush      = ~i_mem_done;
      o_exec_flush     = 1'b0;
      o_decode_flush   = (w_hz & ~w_exec_stall) | w_branch_bubble;
      o_fetch_flush    = w_redirect | ~i_fetch_done;
      o_fetch_redirect = w_redirect;
    end
  end

  // Scoreboard next state: retire clears first so a same-register issue wins
  assign w_issue  = w_active & i_dec_long & i_dec_reg_wb & (i_dec_dst != '0) & ~w_decode_stall;
  assign w_retire = w_active & i_long_done & r_busy[i_long_dst];

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_retire) w_busy_nxt[i_long_dst] = 1'b0;
    if (w_issue)  w_busy_nxt[i_dec_dst]  = 1'b1;
    w_cnt_nxt = r_long_cnt;
    if (w_issue && !w_retire)      w_cnt_nxt = r_long_cnt + cnt_t'(1);
    else if (!w_issue && w_retire) w_cnt_nxt = r_long_cnt - cnt_t'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy       <= '0;
      r_long_cnt   <= '0;
      r_redir_pend <= 1'b0;
      r_redir_addr <= '0;
    end else if (w_active) begin
      r_busy     <= w_busy_nxt;
      r_long_cnt <= w_cnt_nxt;
      // Hold a redirect the fetch stage cannot accept yet
      if (i_exec_branch && w_fetch_stall) begin
        r_redir_pend <= 1'b1;
        r_redir_addr <= i_exec_branch_target;
      end else if (!w_fetch_stall) begin
        r_redir_pend <= 1'b0;
      end
    end
  end

endmodule
